// File: rtl/onewire_bus_master.sv
// 1-wire bit/byte master: reset/presence, byte write/read and single-bit slots on one of
// NUM_BUSES open-drain segments, with standard/overdrive timing and strong pull-up.
module onewire_bus_master #(
    parameter int unsigned CLK_FREQ    = 40_000_000,
    parameter int unsigned NUM_BUSES   = 4,
    parameter int unsigned SYNC_STAGES = 2,
    localparam int unsigned BW = (NUM_BUSES > 1) ? $clog2(NUM_BUSES) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_asy_n_i,
    input  logic                 rst_syn_i,
    input  logic                 cmd_en_i,
    input  logic [1:0]           cmd_i,
    input  logic [7:0]           data_i,
    input  logic [BW-1:0]        bus_sel_i,
    input  logic                 overdrive_i,
    input  logic                 spu_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 cmd_err_o,
    output logic [7:0]           data_o,
    output logic                 presence_o,
    output logic [NUM_BUSES-1:0] strong_pullup_o,
    input  logic [NUM_BUSES-1:0] rx_i,
    output logic [NUM_BUSES-1:0] tx_o
);

    localparam int unsigned Div = CLK_FREQ / 2_000_000;
    localparam int unsigned PW  = (Div > 1) ? $clog2(Div) : 1;

    localparam logic [1:0] CmdRst  = 2'b00;
    localparam logic [1:0] CmdRead = 2'b10;
    localparam logic [1:0] CmdBit  = 2'b11;
    localparam logic [1:0] CmdWrite = 2'b01;

    typedef enum logic [2:0] {
        StIdle, StRstLow, StRstWait, StSlotLow, StSlotRel, StSpu, StDone
    } state_e;

    state_e                 state_q;
    logic [PW-1:0]          presc_q;
    logic [9:0]             cnt_q;
    logic [7:0]             sh_q;
    logic [2:0]             bitcnt_q;
    logic [1:0]             cmd_q;
    logic [BW-1:0]          bus_q;
    logic                   od_q, spu_en_q, samp_q;
    logic                   busy_q, done_q, err_q, pres_q;
    logic [7:0]             data_q;
    logic [NUM_BUSES-1:0]   spu_q, tx_q;
    logic [NUM_BUSES-1:0]   sync_q [SYNC_STAGES];

    function automatic logic [NUM_BUSES-1:0] onehot(input logic [BW-1:0] b);
        logic [NUM_BUSES-1:0] oh;
        for (int unsigned i = 0; i < NUM_BUSES; i++) oh[i] = (32'(b) == i);
        return oh;
    endfunction

    always_ff @(posedge clk_i or negedge rst_asy_n_i) begin
        if (!rst_asy_n_i) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
        end else begin
            sync_q[0] <= rx_i;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    logic       tick, bus_bad, wbit, last_bit, rx_bit;
    logic [9:0] cnt_nxt, t_rst_low, t_pres, t_rst_end, t_low, t_samp, t_slot;

    always_comb begin
        tick      = (presc_q == PW'(Div - 1));
        cnt_nxt   = cnt_q + 10'd1;
        bus_bad   = (32'(bus_sel_i) >= NUM_BUSES);
        rx_bit    = |(sync_q[SYNC_STAGES-1] & onehot(bus_q));
        // Read slots are write-1 slots; the shift register holds samples, not the bit to send.
        wbit      = (cmd_q == CmdRead) ? 1'b1 : sh_q[0];
        last_bit  = (cmd_q == CmdBit) || (bitcnt_q == 3'd7);
        t_rst_low = od_q ? 10'd140 : 10'd960;
        t_pres    = od_q ? 10'd17  : 10'd140;
        t_rst_end = od_q ? 10'd80  : 10'd820;
        t_low     = wbit ? (od_q ? 10'd2 : 10'd12) : (od_q ? 10'd15 : 10'd120);
        t_samp    = od_q ? 10'd4   : 10'd30;
        t_slot    = od_q ? 10'd20  : 10'd140;
    end

    always_ff @(posedge clk_i or negedge rst_asy_n_i) begin
        if (!rst_asy_n_i) begin
            state_q <= StIdle;  presc_q <= '0;  cnt_q <= '0;   sh_q <= '0;
            bitcnt_q <= '0;     cmd_q <= '0;    bus_q <= '0;   od_q <= 1'b0;
            spu_en_q <= 1'b0;   samp_q <= 1'b0; busy_q <= 1'b0; done_q <= 1'b0;
            err_q <= 1'b0;      pres_q <= 1'b0; data_q <= '0;  spu_q <= '0;
            tx_q <= '0;
        end else if (rst_syn_i) begin
            state_q <= StIdle;  presc_q <= '0;  cnt_q <= '0;   sh_q <= '0;
            bitcnt_q <= '0;     cmd_q <= '0;    bus_q <= '0;   od_q <= 1'b0;
            spu_en_q <= 1'b0;   samp_q <= 1'b0; busy_q <= 1'b0; done_q <= 1'b0;
            err_q <= 1'b0;      pres_q <= 1'b0; data_q <= '0;  spu_q <= '0;
            tx_q <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= cmd_en_i && (state_q != StIdle);
            if (state_q == StIdle) presc_q <= '0;
            else                   presc_q <= tick ? '0 : presc_q + PW'(1);
            unique case (state_q)
                StIdle: if (cmd_en_i) begin
                    if (bus_bad) begin
                        err_q <= 1'b1;
                    end else begin
                        cmd_q    <= cmd_i;
                        bus_q    <= bus_sel_i;
                        od_q     <= overdrive_i;
                        spu_en_q <= spu_i;
                        sh_q     <= (cmd_i == CmdRead) ? 8'hFF :
                                    (cmd_i == CmdBit) ? {7'b0, data_i[0]} : data_i;
                        spu_q    <= '0;
                        busy_q   <= 1'b1;
                        cnt_q    <= '0;
                        bitcnt_q <= '0;
                        samp_q   <= 1'b0;
                        tx_q     <= onehot(bus_sel_i);
                        state_q  <= (cmd_i == CmdRst) ? StRstLow : StSlotLow;
                    end
                end
                StRstLow: if (tick) begin
                    cnt_q <= cnt_nxt;
                    if (cnt_nxt == t_rst_low) begin
                        cnt_q   <= '0;
                        tx_q    <= '0;
                        state_q <= StRstWait;
                    end
                end
                StRstWait: if (tick) begin
                    cnt_q <= cnt_nxt;
                    if (cnt_nxt == t_pres) pres_q <= ~rx_bit;
                    if (cnt_nxt == t_rst_end) begin
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StSlotLow: if (tick) begin
                    cnt_q <= cnt_nxt;
                    if (cnt_nxt == t_low) begin
                        tx_q    <= '0;
                        state_q <= StSlotRel;
                    end
                end
                StSlotRel: if (tick) begin
                    cnt_q <= cnt_nxt;
                    if (cnt_nxt == t_samp && wbit) samp_q <= rx_bit;
                    if (cnt_nxt == t_slot) begin
                        cnt_q    <= '0;
                        samp_q   <= 1'b0;
                        sh_q     <= {samp_q, sh_q[7:1]};
                        bitcnt_q <= bitcnt_q + 3'd1;
                        if (!last_bit) begin
                            tx_q    <= onehot(bus_q);
                            state_q <= StSlotLow;
                        end else begin
                            done_q <= 1'b1;
                            if (cmd_q == CmdRead) data_q <= {samp_q, sh_q[7:1]};
                            if (cmd_q == CmdBit)  data_q <= {7'b0, samp_q};
                            if (cmd_q == CmdWrite && spu_en_q) begin
                                spu_q   <= onehot(bus_q);
                                state_q <= StSpu;
                            end else begin
                                state_q <= StDone;
                            end
                        end
                    end
                end
                StSpu, StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign cmd_err_o       = err_q;
    assign data_o          = data_q;
    assign presence_o      = pres_q;
    assign strong_pullup_o = spu_q;
    assign tx_o            = tx_q;

endmodule

// File: tb/tb_onewire_bus_master.sv
// Self-checking bench for onewire_bus_master with a behavioural slave and slot-timing model.
`timescale 1ns/1ps
module tb_onewire_bus_master;

    localparam int unsigned CLK_FREQ = 4_000_000;
    localparam int NB    = 5;
    localparam int DIV   = 2;
    localparam int BOUND = 5000;

    logic          clk = 1'b0;
    logic          rst_asy_n, rst_syn, cmd_en, overdrive, spu;
    logic [1:0]    cmd;
    logic [7:0]    data;
    logic [2:0]    bus_sel;
    logic          busy, done, cmd_err, presence;
    logic [7:0]    data_out;
    logic [NB-1:0] spu_out, tx, rx, s_low;

    onewire_bus_master #(.CLK_FREQ(CLK_FREQ), .NUM_BUSES(NB), .SYNC_STAGES(2)) dut (
        .clk_i(clk), .rst_asy_n_i(rst_asy_n), .rst_syn_i(rst_syn), .cmd_en_i(cmd_en),
        .cmd_i(cmd), .data_i(data), .bus_sel_i(bus_sel), .overdrive_i(overdrive),
        .spu_i(spu), .busy_o(busy), .done_o(done), .cmd_err_o(cmd_err), .data_o(data_out),
        .presence_o(presence), .strong_pullup_o(spu_out), .rx_i(rx), .tx_o(tx)
    );

    always #5 clk = ~clk;
    assign rx = ~(tx | s_low);

    int checks = 0, errors = 0, cyc = 0;
    always @(posedge clk) cyc++;

    // Behavioural slave: presence pulse after reset, or answers a byte LSB first in read slots.
    int         s_mode = 0, s_bus = 0, s_rel = -1, s_start = 0, s_idx = -1;
    logic [7:0] s_byte = 8'h00;
    logic       s_od = 1'b0, s_prev = 1'b0;
    always @(negedge clk) begin
        if (tx[s_bus] && !s_prev) begin s_start = cyc; s_idx++; end
        if (!tx[s_bus] && s_prev) s_rel = cyc;
        s_prev = tx[s_bus];
        s_low  = '0;
        if (s_mode == 1 && s_rel >= 0 && !tx[s_bus] && (cyc - s_rel) >= 100*DIV
            && (cyc - s_rel) < 300*DIV) s_low[s_bus] = 1'b1;
        if (s_mode == 2 && s_idx >= 0 && s_idx < 8 && !s_byte[s_idx]
            && (cyc - s_start) >= 2*DIV && (cyc - s_start) < (s_od ? 12 : 60)*DIV)
            s_low[s_bus] = 1'b1;
    end

    task automatic arm_slave(input int mode, input int b, input logic [7:0] by, input logic od);
        s_mode = mode; s_bus = b; s_byte = by; s_od = od;
        s_rel = -1; s_idx = -1; s_prev = tx[b];
    endtask

    function automatic logic [NB-1:0] oh(input int b);
        logic [NB-1:0] r;
        r = '0;
        r[b] = 1'b1;
        return r;
    endfunction

    int            lows[$], starts[$], falls[$];
    int            n_done, n_err, done_t;
    bit            timed_out, other_tx, busy_gap;
    logic [NB-1:0] spu_first;

    // Issue one command and record tx activity on the target bus until done_o or the bound.
    task automatic run_cmd(input logic [1:0] c, input logic [7:0] d, input int b,
                           input logic od, input logic sp, input int err_at);
        int t;
        logic prev;
        lows.delete(); starts.delete(); falls.delete();
        n_done = 0; n_err = 0; done_t = -1; timed_out = 0; other_tx = 0; busy_gap = 0;
        @(negedge clk);
        cmd_en = 1'b1; cmd = c; data = d; bus_sel = 3'(b); overdrive = od; spu = sp;
        @(negedge clk);
        cmd_en = 1'b0; overdrive = ~od;
        prev = 1'b0; t = 0;
        spu_first = spu_out;
        while (t < BOUND) begin
            if (tx[b] && !prev) starts.push_back(t);
            if (!tx[b] && prev) begin lows.push_back(t - starts[$]); falls.push_back(t); end
            prev = tx[b];
            if ((tx & ~oh(b)) != '0) other_tx = 1;
            if (cmd_err) n_err++;
            if (!busy) busy_gap = 1;
            if (done) begin n_done++; done_t = t; break; end
            if (err_at > 0 && t == err_at) begin
                cmd_en = 1'b1; cmd = 2'b00; bus_sel = 3'd0;
            end else begin
                cmd_en = 1'b0;
            end
            @(negedge clk);
            t++;
        end
        cmd_en = 1'b0;
        if (t >= BOUND) timed_out = 1;
    endtask

    task automatic test_reset;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", cmd_err); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", data_out); end
        checks++; if (presence !== 1'b0) begin errors++; $display("FAIL reset_pres got %b want 0", presence); end
        checks++; if (spu_out !== '0) begin errors++; $display("FAIL reset_spu got %b want 0", spu_out); end
        checks++; if (tx !== '0) begin errors++; $display("FAIL reset_tx got %b want 0", tx); end
    endtask

    task automatic test_reset_cmd(input int b, input logic present);
        arm_slave(present ? 1 : 0, b, 8'h00, 1'b0);
        run_cmd(2'b00, 8'($urandom), b, 1'b0, 1'b0, 0);
        checks++; if (timed_out || lows.size() != 1) begin
            errors++; $display("FAIL rst_shape timeout=%0d lows=%0d want 0,1", timed_out, lows.size());
        end
        if (lows.size() == 1) begin
            checks++; if (lows[0] != 960*DIV) begin
                errors++; $display("FAIL rst_low got %0d want %0d", lows[0], 960*DIV); end
            checks++; if (done_t - falls[0] != 820*DIV) begin
                errors++; $display("FAIL rst_wait got %0d want %0d", done_t - falls[0], 820*DIV); end
        end
        checks++; if (presence !== present) begin
            errors++; $display("FAIL rst_presence got %b want %b", presence, present); end
        checks++; if (other_tx || busy_gap) begin
            errors++; $display("FAIL rst_side other_tx=%0d busy_gap=%0d want 0,0", other_tx, busy_gap); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_end done=%b busy=%b want 0,0", done, busy); end
    endtask

    task automatic test_write(input int b, input logic [7:0] d, input logic od, input logic sp);
        int lo0, lo1, slot, bad;
        lo0 = od ? 15 : 120; lo1 = od ? 2 : 12; slot = od ? 20 : 140;
        arm_slave(0, b, 8'h00, od);
        run_cmd(2'b01, d, b, od, sp, 0);
        checks++; if (timed_out || lows.size() != 8 || n_done != 1) begin
            errors++; $display("FAIL wr_shape timeout=%0d slots=%0d done=%0d want 0,8,1",
                               timed_out, lows.size(), n_done);
        end
        if (lows.size() == 8) begin
            bad = 0;
            for (int i = 0; i < 8; i++) if (lows[i] != (d[i] ? lo1 : lo0)*DIV) bad++;
            checks++; if (bad != 0) begin
                errors++; $display("FAIL wr_lows data=%h bad_slots=%0d want 0", d, bad); end
            bad = 0;
            for (int i = 0; i < 7; i++) if (starts[i+1] - starts[i] != slot*DIV) bad++;
            if (done_t - starts[7] != slot*DIV) bad++;
            checks++; if (bad != 0) begin
                errors++; $display("FAIL wr_period bad_slots=%0d want 0", bad); end
        end
        checks++; if (spu_out !== (sp ? oh(b) : '0)) begin
            errors++; $display("FAIL wr_spu got %b want %b", spu_out, sp ? oh(b) : '0); end
        checks++; if (other_tx || busy_gap) begin
            errors++; $display("FAIL wr_side other_tx=%0d busy_gap=%0d want 0,0", other_tx, busy_gap); end
        repeat (20) @(negedge clk);
        checks++; if (spu_out !== (sp ? oh(b) : '0) || tx !== '0) begin
            errors++; $display("FAIL wr_hold spu=%b tx=%b", spu_out, tx); end
    endtask

    task automatic test_read(input int b, input logic [7:0] by, input logic od, input int err_at);
        int bad;
        arm_slave(2, b, by, od);
        run_cmd(2'b10, 8'($urandom), b, od, 1'b0, err_at);
        checks++; if (timed_out || lows.size() != 8 || n_done != 1) begin
            errors++; $display("FAIL rd_shape timeout=%0d slots=%0d done=%0d want 0,8,1",
                               timed_out, lows.size(), n_done);
        end
        checks++; if (data_out !== by) begin
            errors++; $display("FAIL rd_data got %h want %h", data_out, by); end
        checks++; if (n_err != (err_at > 0 ? 1 : 0)) begin
            errors++; $display("FAIL rd_err got %0d want %0d", n_err, err_at > 0 ? 1 : 0); end
        if (starts.size() == 8) begin
            bad = 0;
            for (int i = 0; i < 7; i++) if (starts[i+1] - starts[i] != (od ? 20 : 140)*DIV) bad++;
            checks++; if (bad != 0) begin
                errors++; $display("FAIL rd_period bad_slots=%0d want 0", bad); end
        end
    endtask

    task automatic test_single_bit;
        logic [7:0] d, sb, exp;
        int b;
        logic od;
        for (int k = 0; k < 4; k++) begin
            d = 8'($urandom); sb = 8'($urandom); b = $urandom_range(0, NB-1);
            od = 1'($urandom_range(0, 1));
            exp = d[0] ? {7'b0, sb[0]} : 8'h00;
            arm_slave(2, b, sb, od);
            run_cmd(2'b11, d, b, od, 1'b0, 0);
            checks++; if (timed_out || lows.size() != 1 || data_out !== exp) begin
                errors++; $display("FAIL bit_data d=%h slave=%h got %h slots=%0d want %h,1",
                                   d, sb, data_out, lows.size(), exp);
            end
        end
    endtask

    task automatic test_bad_bus;
        bit act;
        @(negedge clk);
        cmd_en = 1'b1; cmd = 2'b01; data = 8'h00; bus_sel = 3'd5;
        @(negedge clk);
        cmd_en = 1'b0;
        checks++; if (cmd_err !== 1'b1) begin
            errors++; $display("FAIL badbus_err got %b want 1", cmd_err); end
        act = 0;
        repeat (30) begin @(negedge clk); if (busy || tx != '0 || cmd_err) act = 1; end
        checks++; if (act) begin errors++; $display("FAIL badbus_idle got activity want none"); end
    endtask

    task automatic test_spu_clear;
        arm_slave(0, 1, 8'h00, 1'b0);
        run_cmd(2'b00, 8'h00, 1, 1'b0, 1'b0, 0);
        checks++; if (spu_first !== '0) begin
            errors++; $display("FAIL spu_clear got %b want 0", spu_first); end
    endtask

    task automatic test_sync_reset;
        bit seen;
        @(negedge clk);
        cmd_en = 1'b1; rst_syn = 1'b1; cmd = 2'b00; bus_sel = 3'd2;
        @(negedge clk);
        cmd_en = 1'b0; rst_syn = 1'b0;
        seen = 0;
        repeat (10) begin if (busy || tx != '0) seen = 1; @(negedge clk); end
        checks++; if (seen) begin errors++; $display("FAIL syn_cmd_drop got activity want none"); end
        @(negedge clk);
        cmd_en = 1'b1; cmd = 2'b01; data = 8'h00; bus_sel = 3'd2; overdrive = 1'b0;
        @(negedge clk);
        cmd_en = 1'b0;
        repeat (30) @(negedge clk);
        checks++; if (tx !== oh(2)) begin errors++; $display("FAIL syn_pre_tx got %b want %b", tx, oh(2)); end
        rst_syn = 1'b1;
        @(negedge clk);
        rst_syn = 1'b0;
        checks++; if (tx !== '0 || busy !== 1'b0) begin
            errors++; $display("FAIL syn_mid tx=%b busy=%b want 0,0", tx, busy); end
        seen = 0;
        repeat (300) begin @(negedge clk); if (done || tx != '0) seen = 1; end
        checks++; if (seen) begin errors++; $display("FAIL syn_mid_done got activity want none"); end
    endtask

    task automatic test_async_reset;
        int t, rises;
        logic prev;
        bit seen;
        arm_slave(0, 0, 8'h00, 1'b0);
        @(negedge clk);
        cmd_en = 1'b1; cmd = 2'b01; data = 8'h5A; bus_sel = 3'd0; overdrive = 1'b0; spu = 1'b0;
        @(negedge clk);
        cmd_en = 1'b0;
        rises = 1; prev = tx[0]; t = 0;
        while (rises < 4 && t < BOUND) begin
            @(negedge clk); t++;
            if (tx[0] && !prev) rises++;
            prev = tx[0];
        end
        checks++; if (t >= BOUND) begin errors++; $display("FAIL arst_bit3 timeout waiting slot 3"); end
        #2 rst_asy_n = 1'b0;
        #1;
        checks++; if (tx !== '0 || busy !== 1'b0 || done !== 1'b0 || cmd_err !== 1'b0) begin
            errors++; $display("FAIL arst_now tx=%b busy=%b done=%b err=%b want 0", tx, busy, done, cmd_err);
        end
        checks++; if (data_out !== 8'h00 || presence !== 1'b0 || spu_out !== '0) begin
            errors++; $display("FAIL arst_regs data=%h pres=%b spu=%b want 0", data_out, presence, spu_out);
        end
        seen = 0;
        repeat (10) begin @(negedge clk); if (done || busy) seen = 1; end
        rst_asy_n = 1'b1;
        repeat (200) begin @(negedge clk); if (done || busy || tx != '0) seen = 1; end
        checks++; if (seen) begin errors++; $display("FAIL arst_no_done got activity want none"); end
        test_reset_cmd(0, 1'b1);
    endtask

    initial begin
        rst_asy_n = 1'b0; rst_syn = 1'b0; cmd_en = 1'b0; cmd = 2'b00; data = 8'h00;
        bus_sel = 3'd0; overdrive = 1'b0; spu = 1'b0; s_low = '0;
        repeat (3) @(negedge clk);
        test_reset;
        rst_asy_n = 1'b1;
        test_reset_cmd(2, 1'b1);
        test_reset_cmd(2, 1'b0);
        test_write(0, 8'hA5, 1'b0, 1'b0);
        test_write($urandom_range(0, NB-1), 8'($urandom), 1'b1, 1'b0);
        test_read(3, 8'h3C, 1'b1, 0);
        test_read($urandom_range(0, NB-1), 8'($urandom), 1'b1, 0);
        test_write(1, 8'h44, 1'b0, 1'b1);
        test_spu_clear;
        test_read(3, 8'($urandom), 1'b0, 500);
        test_single_bit;
        test_bad_bus;
        test_sync_reset;
        test_async_reset;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
